// File: rtl/dii_package.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dii_package : DII flit type and shared constants for the debug ring  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package dii_package;

   localparam int c_dii_data_w = 16;

   typedef struct packed {
      logic                    valid;
      logic                    last;
      logic [c_dii_data_w-1:0] data;
   } dii_flit;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dii_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dii_skid_buffer : 2-entry registered valid/ready slice for DII flits |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module dii_skid_buffer
   import dii_package::*;
(
   input  logic    clk,
   input  logic    rst,
   input  dii_flit in_flit,
   output logic    in_ready,
   output dii_flit out_flit,
   input  logic    out_ready
);

   logic [1:0] r_count;
   dii_flit    r_head;
   dii_flit    r_tail;
   logic       w_push;
   logic       w_pop;

   // Ready depends only on registered occupancy, so no sink-to-source path.
   assign in_ready = (r_count != 2'd2);
   assign w_push   = in_flit.valid && in_ready;
   assign w_pop    = (r_count != 2'd0) && out_ready;

   always_comb begin
      out_flit       = r_head;
      out_flit.valid = (r_count != 2'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= in_flit;
               else                 r_tail <= in_flit;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            // Push and pop together only happens with one entry held.
            2'b11:   r_head <= in_flit;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dii_packet_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dii_packet_arbiter : packet-atomic round-robin DII flit arbiter      |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module dii_packet_arbiter
   import dii_package::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  dii_flit [NUM_PORTS-1:0]  in_flit,
   output logic    [NUM_PORTS-1:0]  in_ready,
   output dii_flit                  out_flit,
   input  logic                     out_ready,
   output logic    [IDX_W-1:0]      grant_idx,
   output logic                     busy
);

   arb_state_e           r_state;
   arb_state_e           w_state_nxt;
   logic [IDX_W-1:0]     r_grant;
   logic [IDX_W-1:0]     w_grant_nxt;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     w_rr_ptr_nxt;
   logic [NUM_PORTS-1:0] w_valid_vec;
   logic                 w_found;
   logic [IDX_W-1:0]     w_winner;
   dii_flit              w_sel;
   dii_flit              w_buf_in;
   logic                 w_buf_ready;
   logic                 w_accept;

   // Explicit modulo wrap so non-power-of-two port counts rotate correctly.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return IDX_W'(s);
   endfunction

   assign busy      = (r_state == ARB_LOCKED);
   assign grant_idx = r_grant;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign w_valid_vec[i] = in_flit[i].valid;
      assign in_ready[i]    = busy && (r_grant == IDX_W'(i)) && w_buf_ready;
   end

   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!w_found && w_valid_vec[wrap_add(r_rr_ptr, k)]) begin
            w_found  = 1'b1;
            w_winner = wrap_add(r_rr_ptr, k);
         end
      end
   end

   always_comb begin
      w_sel          = in_flit[r_grant];
      w_buf_in       = w_sel;
      w_buf_in.valid = w_sel.valid && busy;
   end

   assign w_accept = w_buf_in.valid && w_buf_ready;

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_ptr_nxt = r_rr_ptr;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_grant_nxt = w_winner;
               w_state_nxt = ARB_LOCKED;
            end
         end
         ARB_LOCKED: begin
            if (w_accept && w_sel.last) begin
               w_rr_ptr_nxt = wrap_add(r_grant, 1);
               w_state_nxt  = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ARB_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   dii_skid_buffer u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (w_buf_in),
      .in_ready  (w_buf_ready),
      .out_flit  (out_flit),
      .out_ready (out_ready)
   );

endmodule
`default_nettype wire

// File: tb/tb_dii_packet_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dii_packet_arbiter : randomized bench with a queue-based model    |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
module tb_dii_packet_arbiter;
   import dii_package::*;

   localparam int NP = 3;
   localparam int IW = $clog2(NP);

   logic                clk;
   logic                rst;
   dii_flit [NP-1:0]    in_flit;
   logic    [NP-1:0]    in_ready;
   dii_flit             out_flit;
   logic                out_ready;
   logic    [IW-1:0]    grant_idx;
   logic                busy;

   dii_packet_arbiter #(.NUM_PORTS(NP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_ready (out_ready),
      .grant_idx (grant_idx),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         if (bad <= 25) $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Sources: per-port flit queues, held stable until accepted.
   dii_flit src_q[NP][$];
   bit      show[NP];
   bit      acc[NP];
   int      hold[NP];
   int      acc_cnt[NP];
   int      gap_pct, ordy_pct;
   bit      ordy_pat;
   int      pat_i, cyc;
   int      n_out, n_loaded;
   bit      prev_busy;
   int      owners[$];

   // Reference model: lock owner, rotating pointer, FIFO of at most two flits.
   bit      m_locked;
   int      m_owner, m_ptr;
   dii_flit m_q[$];

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_ptr = 0;
      m_q.delete();
   endtask

   task automatic model_step();
      bit      push, pop;
      dii_flit f;
      f    = in_flit[m_owner];
      push = m_locked && f.valid && (m_q.size() < 2);
      pop  = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(f);
      if (!m_locked) begin
         for (int k = 0; k < NP; k++) begin
            int p;
            p = (m_ptr + k) % NP;
            if (in_flit[p].valid) begin
               m_locked = 1; m_owner = p;
               break;
            end
         end
      end else if (push && f.last) begin
         m_locked = 0;
         m_ptr    = (m_owner + 1) % NP;
      end
   endtask

   task automatic check_outputs();
      logic [NP-1:0] er;
      for (int i = 0; i < NP; i++) er[i] = m_locked && (m_owner == i) && (m_q.size() < 2);
      chk("busy", 32'(busy), 32'(m_locked));
      if (m_locked) chk("grant_idx", 32'(grant_idx), 32'(m_owner));
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("out_valid", 32'(out_flit.valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("out_flit", 32'(out_flit), 32'(m_q[0]));
      if (busy && !prev_busy) owners.push_back(int'(grant_idx));
      prev_busy = busy;
   endtask

   task automatic cycle();
      bit [3:0] pat;
      pat = 4'b1001;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NP; i++) begin
         if (acc[i]) begin
            void'(src_q[i].pop_front());
            show[i] = 0;
         end
      end
      check_outputs();
      for (int i = 0; i < NP; i++) begin
         if (hold[i] > 0) hold[i]--;
         else if (!show[i] && src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) show[i] = 1;
         in_flit[i] = show[i] ? src_q[i][0] : '0;
      end
      if (ordy_pat) begin
         out_ready = pat[pat_i % 4];
         pat_i++;
      end else begin
         out_ready = ($urandom_range(99) < ordy_pct);
      end
      for (int i = 0; i < NP; i++) begin
         acc[i] = in_flit[i].valid && in_ready[i];
         if (acc[i]) acc_cnt[i]++;
      end
      if (out_flit.valid && out_ready) n_out++;
      model_step();
   endtask

   task automatic load_pkt(input int p, input int len, input logic [15:0] base);
      dii_flit f;
      for (int k = 0; k < len; k++) begin
         f.valid = 1'b1;
         f.last  = (k == len - 1);
         f.data  = base + 16'(k);
         src_q[p].push_back(f);
         n_loaded++;
      end
   endtask

   function automatic bit pending();
      bit r;
      r = 0;
      for (int i = 0; i < NP; i++) if (src_q[i].size() > 0) r = 1;
      return r;
   endfunction

   task automatic begin_scn();
      n_out = 0; n_loaded = 0;
      owners.delete();
      for (int i = 0; i < NP; i++) acc_cnt[i] = 0;
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((pending() || m_q.size() > 0 || m_locked) && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
      chk({tag, "_count"}, 32'(n_out), 32'(n_loaded));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0, t1;
      rst = 1'b1; in_flit = '0; out_ready = 1'b0;
      gap_pct = 0; ordy_pct = 100; ordy_pat = 0; pat_i = 0; cyc = 0; prev_busy = 0;
      for (int i = 0; i < NP; i++) begin show[i] = 0; acc[i] = 0; hold[i] = 0; end
      model_reset();
      begin_scn();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_idx), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_flit.valid), 32'd0);
      rst = 1'b0;

      // Single requester on port 1, latency from valid to output.
      begin_scn();
      load_pkt(1, 3, 16'hA001);
      t0 = -1; t1 = -1;
      for (int n = 0; n < 20; n++) begin
         cycle();
         if (t0 < 0 && in_flit[1].valid) t0 = cyc;
         if (t1 < 0 && out_flit.valid)   t1 = cyc;
      end
      chk("first_latency", 32'(t1 - t0), 32'd2);
      run_idle("single", 100);

      // Fairness between ports 0 and 1 (pointer now at 2, so port 0 first).
      begin_scn();
      for (int k = 0; k < 6; k++) begin
         load_pkt(0, 2, 16'h0100 + 16'(k * 16));
         load_pkt(1, 2, 16'h1100 + 16'(k * 16));
      end
      run_idle("fair", 500);
      chk("fair_npkts", 32'(owners.size()), 32'd12);
      for (int k = 0; k < owners.size(); k++) chk("fair_alternate", 32'(owners[k]), 32'(k % 2));

      // Backpressure pattern 1,0,0,1 during a 4-flit packet.
      begin_scn();
      ordy_pat = 1; pat_i = 0;
      load_pkt(2, 4, 16'hB000);
      run_idle("backpressure", 200);
      ordy_pat = 0;

      // Single-flit packets on all ports, round-robin with wrap.
      begin_scn();
      for (int k = 0; k < 3; k++) begin
         load_pkt(0, 1, 16'h0010);
         load_pkt(1, 1, 16'h0020);
         load_pkt(2, 1, 16'h0030);
      end
      run_idle("single_flit", 300);
      for (int k = 0; k < owners.size(); k++) chk("sf_order", 32'(owners[k]), 32'(k % 3));

      // Port 0 stalls mid-packet while port 1 waits.
      begin_scn();
      load_pkt(0, 4, 16'hC000);
      load_pkt(1, 2, 16'hD000);
      for (int n = 0; n < 50 && acc_cnt[0] < 2; n++) cycle();
      hold[0] = 10;
      run_idle("stall", 300);
      chk("stall_first_owner", 32'(owners.size() > 0 ? owners[0] : -1), 32'd0);

      // Randomized traffic with gaps and random sink backpressure.
      begin_scn();
      gap_pct = 30; ordy_pct = 65;
      for (int n = 0; n < 800; n++) begin
         for (int p = 0; p < NP; p++)
            if (src_q[p].size() < 8 && $urandom_range(9) == 0)
               load_pkt(p, int'($urandom_range(1, 4)), 16'($urandom));
         cycle();
      end
      run_idle("random", 3000);

      // Asynchronous reset in the middle of a packet.
      begin_scn();
      gap_pct = 0; ordy_pct = 100;
      load_pkt(0, 4, 16'hE000);
      load_pkt(1, 4, 16'hF000);
      for (int n = 0; n < 50 && (acc_cnt[0] + acc_cnt[1]) < 2; n++) cycle();
      #2 rst = 1'b1;
      #1;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_out_valid", 32'(out_flit.valid), 32'd0);
      chk("rstmid_in_ready", 32'(in_ready), 32'd0);
      model_reset();
      for (int i = 0; i < NP; i++) begin
         src_q[i].delete(); show[i] = 0; acc[i] = 0; hold[i] = 0;
      end
      in_flit = '0; prev_busy = 0;
      @(negedge clk);
      rst = 1'b0;
      begin_scn();
      load_pkt(1, 2, 16'h5100);
      load_pkt(0, 2, 16'h5000);
      run_idle("after_reset", 200);
      chk("rearb_seen", 32'(owners.size() > 0), 32'd1);
      chk("rearb_owner", 32'(owners.size() > 0 ? owners[0] : -1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
